alu_writeback_unit: RTL and testbench

//  Downstream of the 32-bit ALU. Accepts one ALU result per handshake (result, zero, cout,

---
 rtl/alu_writeback_unit.sv | 181 ++++++++++++++++++
 tb/tb_alu_writeback_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_unit.sv
// ALU writeback: 2-entry result buffer committing into a 32-entry register file and {N,Z,C,V} status.
// Optional macro ALU_WB_BYPASS_EN forwards the committing result to the read ports.
module alu_writeback_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_result,
    input  logic                 in_zero,
    input  logic                 in_cout,
    input  logic                 in_overflow,
    input  logic [ADDR_W-1:0]    in_rd,
    input  logic                 in_we,
    input  logic                 in_flag_we,
    input  logic                 hold,
    input  logic                 ovf_clr,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    output logic                 hazard,
    output logic [3:0]           flags,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 wb_valid,
    output logic [ADDR_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]    wb_data
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              cout;
        logic              overflow;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              flag_we;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e               state_q, state_d;
    entry_t               head_q, head_d, tail_q, tail_d;
    entry_t               in_entry;
    logic [DATA_W-1:0]    regs_q [NumRegs];
    logic [3:0]           flags_q;
    logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
    logic                 wb_valid_q;
    logic [ADDR_W-1:0]    wb_rd_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic                 push, pop, commit_we;

    assign in_entry = '{result: in_result, zero: in_zero, cout: in_cout, overflow: in_overflow,
                        rd: in_rd, we: in_we, flag_we: in_flag_we};

    // Gated by rst_n so in_ready stays low throughout reset.
    assign in_ready  = rst_n & (state_q != StFull);
    assign push      = in_valid & in_ready;
    assign pop       = (state_q != StEmpty) & ~hold;
    assign commit_we = pop & head_q.we & (head_q.rd != '0);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    tail_d  = in_entry;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_we) begin
            regs_q[head_q.rd] <= head_q.result;
        end
    end

    // Clear has priority over a same-cycle overflow commit.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end else if (pop && head_q.flag_we && head_q.overflow && !(&ovf_q)) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= '0;
            ovf_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ovf_q      <= ovf_d;
            wb_valid_q <= pop;
            if (pop) begin
                wb_rd_q   <= head_q.rd;
                wb_data_q <= head_q.result;
                if (head_q.flag_we) begin
                    flags_q <= {head_q.result[DATA_W-1], head_q.zero, head_q.cout,
                                head_q.overflow};
                end
            end
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = regs_q[rs_addr];
`ifdef ALU_WB_BYPASS_EN
            if (commit_we && (head_q.rd == rs_addr)) rs_data = head_q.result;
`endif
        end
        if (rt_addr != '0) begin
            rt_data = regs_q[rt_addr];
`ifdef ALU_WB_BYPASS_EN
            if (commit_we && (head_q.rd == rt_addr)) rt_data = head_q.result;
`endif
        end
    end

    function automatic logic entry_hits(entry_t e, logic [ADDR_W-1:0] a, logic [ADDR_W-1:0] b);
        return e.we && (e.rd != '0) && ((e.rd == a) || (e.rd == b));
    endfunction

    assign hazard = ((state_q != StEmpty) && entry_hits(head_q, rs_addr, rt_addr)) ||
                    ((state_q == StFull) && entry_hits(tail_q, rs_addr, rt_addr));

    assign flags     = flags_q;
    assign ovf_count = ovf_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Bench for alu_writeback_unit: directed scenarios plus random traffic against a queue-based model.
module tb_alu_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_zero, in_cout, in_overflow;
    logic [4:0]  in_rd;
    logic        in_we, in_flag_we, hold, ovf_clr;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        hazard;
    logic [3:0]  flags;
    logic [7:0]  ovf_count;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    alu_writeback_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_cout(in_cout),
        .in_overflow(in_overflow), .in_rd(in_rd), .in_we(in_we), .in_flag_we(in_flag_we),
        .hold(hold), .ovf_clr(ovf_clr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .hazard(hazard), .flags(flags),
        .ovf_count(ovf_count), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO of pending results and the architectural state they update.
    typedef struct {
        logic [31:0] result;
        bit          zero, cout, ovf;
        bit [4:0]    rd;
        bit          we, fwe;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_regs [32];
    logic [3:0]  m_flags;
    int          m_cnt;
    bit          m_wbv;
    logic [4:0]  m_wbrd;
    logic [31:0] m_wbdata;

    function automatic void model_reset();
        q.delete();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_flags  = '0;
        m_cnt    = 0;
        m_wbv    = 0;
        m_wbrd   = '0;
        m_wbdata = '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef ALU_WB_BYPASS_EN
        if (q.size() > 0 && !hold && q[0].we && q[0].rd != 0 && q[0].rd == a) return q[0].result;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_hazard();
        foreach (q[i]) begin
            if (q[i].we && q[i].rd != 0 && (q[i].rd == rs_addr || q[i].rd == rt_addr)) return 1;
        end
        return 0;
    endfunction

    function automatic void model_step();
        bit   pop  = (q.size() > 0) && !hold;
        bit   push = in_valid && (q.size() < 2);
        ent_t h;
        m_wbv = 0;
        if (pop) begin
            h = q.pop_front();
            if (h.we && h.rd != 0) m_regs[h.rd] = h.result;
            if (h.fwe) m_flags = {h.result[31], h.zero, h.cout, h.ovf};
            if (h.fwe && h.ovf && m_cnt < 255) m_cnt++;
            m_wbv    = 1;
            m_wbrd   = h.rd;
            m_wbdata = h.result;
        end
        if (ovf_clr) m_cnt = 0;
        if (push) begin
            h = '{result: in_result, zero: in_zero, cout: in_cout, ovf: in_overflow,
                  rd: in_rd, we: in_we, fwe: in_flag_we};
            q.push_back(h);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        check("in_ready", in_ready, (rst_n && q.size() < 2));
        check("rs_data", rs_data, m_read(rs_addr));
        check("rt_data", rt_data, m_read(rt_addr));
        check("hazard", hazard, m_hazard());
        check("flags", flags, m_flags);
        check("ovf_count", ovf_count, m_cnt);
        check("wb_valid", wb_valid, m_wbv);
        if (m_wbv) begin
            check("wb_rd", wb_rd, m_wbrd);
            check("wb_data", wb_data, m_wbdata);
        end
        if (rst_n) model_step();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_result = '0; in_zero = 0; in_cout = 0; in_overflow = 0;
        in_rd = '0; in_we = 0; in_flag_we = 0; hold = 0; ovf_clr = 0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] res, input bit we,
                         input bit fwe, input bit ovf, input bit cout);
        in_valid = 1; in_rd = rd; in_result = res; in_we = we; in_flag_we = fwe;
        in_overflow = ovf; in_cout = cout; in_zero = (res == 0);
    endtask

    initial begin
        idle();
        rs_addr = '0;
        rt_addr = '0;
        rst_n   = 0;
        repeat (3) cyc();
        check("rst_in_ready", in_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        rst_n = 1;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // 1: single commit
        rs_addr = 5'd3;
        offer(5'd3, 32'h5, 1, 1, 0, 0);
        cyc();
        idle();
        cyc();
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_rd", wb_rd, 3);
        check("t1_wb_data", wb_data, 32'h5);
        check("t1_flags", flags, 4'b0000);
        check("t1_r3", rs_data, 32'h5);

        // 2: fill under hold, third refused, ordered drain
        hold = 1;
        offer(5'd4, 32'h11, 1, 0, 0, 0);
        cyc();
        offer(5'd5, 32'h22, 1, 0, 0, 0);
        cyc();
        check("t2_full_ready", in_ready, 0);
        offer(5'd6, 32'h33, 1, 0, 0, 0);
        cyc();
        check("t2_hold_no_commit", wb_valid, 0);
        idle();
        cyc();
        check("t2_first_rd", wb_rd, 4);
        check("t2_ready_after_pop", in_ready, 1);
        cyc();
        check("t2_second_rd", wb_rd, 5);
        cyc();
        check("t2_drained", wb_valid, 0);

        // 3: write to r0 is discarded but still reported
        rs_addr = 5'd0;
        offer(5'd0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        cyc();
        idle();
        cyc();
        check("t3_wb_valid", wb_valid, 1);
        check("t3_wb_data", wb_data, 32'hFFFF_FFFF);
        check("t3_r0", rs_data, 0);

        // 4: overflow counter saturation then clear
        for (int i = 0; i < 300; i++) begin
            offer(5'd9, 32'h8000_0000, 0, 1, 1, 1);
            cyc();
        end
        idle();
        cyc();
        cyc();
        check("t4_flags", flags, 4'b1011);
        check("t4_saturated", ovf_count, 255);
        offer(5'd9, 32'h8000_0000, 0, 1, 1, 1);
        cyc();
        idle();
        ovf_clr = 1;
        cyc();
        ovf_clr = 0;
        check("t4_clear_wins", ovf_count, 0);
        check("t4_clear_commit", wb_valid, 1);

        // 5: hazard and bypass timing
        rs_addr = 5'd7;
        hold    = 1;
        offer(5'd7, 32'hABCD, 1, 0, 0, 0);
        cyc();
        in_valid = 0;
        #1;
        check("t5_hazard_held", hazard, 1);
        cyc();
        hold = 0;
        #1;
        check("t5_hazard_committing", hazard, 1);
`ifdef ALU_WB_BYPASS_EN
        check("t5_bypass", rs_data, 32'hABCD);
`else
        check("t5_no_bypass", rs_data, 32'h0);
`endif
        cyc();
        check("t5_new_value", rs_data, 32'hABCD);
        check("t5_hazard_clear", hazard, 0);

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            in_valid    = $urandom_range(0, 1);
            in_result   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            in_zero     = $urandom_range(0, 1);
            in_cout     = $urandom_range(0, 1);
            in_overflow = $urandom_range(0, 1);
            in_rd       = 5'($urandom_range(0, 7));
            in_we       = $urandom_range(0, 1);
            in_flag_we  = $urandom_range(0, 1);
            hold        = ($urandom_range(0, 3) == 0);
            ovf_clr     = ($urandom_range(0, 15) == 0);
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 31));
            cyc();
        end

        // 6: async reset with a full buffer
        idle();
        hold    = 1;
        rs_addr = 5'd12;
        rt_addr = 5'd13;
        offer(5'd12, 32'h1234, 1, 1, 1, 1);
        cyc();
        offer(5'd13, 32'h5678, 1, 1, 1, 1);
        cyc();
        idle();
        hold = 1;
        check("t6_full", in_ready, 0);
        rst_n = 0;
        #1;
        check("t6_in_ready", in_ready, 0);
        check("t6_flags", flags, 0);
        check("t6_ovf", ovf_count, 0);
        check("t6_wb", {wb_valid, wb_rd, wb_data}, 0);
        check("t6_hazard", hazard, 0);
        check("t6_rs", rs_data, 0);
        repeat (2) cyc();
        hold  = 0;
        rst_n = 1;
        repeat (3) begin
            cyc();
            check("t6_no_commit", wb_valid, 0);
        end
        check("t6_r12", rs_data, 0);
        check("t6_r13", rt_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
